// File: rtl/normalise_prod_mult_descale.sv
// Normalises the 50-bit multiply product to a 24-bit mantissa, denormalises and rounds it (RNE).
// Latency: fixed 2 cycles (stage 1 normalise/denormalise, stage 2 round/exponent fix-up).
// No backpressure: one operation accepted every clock, never stalls.
module normalise_prod_mult_descale #(
   parameter bit ROUND_EN  = 1'b1,
   parameter bit DENORM_EN = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        idle_Multiply,
   input  logic [32:0] zout_Multiply,
   input  logic [49:0] productout_Multiply,
   input  logic [7:0]  InsTagMultiply,
   input  logic        ScaleValidMultiply,
   input  logic [31:0] z_Multiply,
   output logic        idle_NormaliseProd,
   output logic [32:0] zout_NormaliseProd,
   output logic [7:0]  InsTagNormaliseProd,
   output logic        ScaleValidNormaliseProd,
   output logic [31:0] z_NormaliseProd,
   output logic        overflow_NormaliseProd,
   output logic        underflow_NormaliseProd
);

   // stage 1 registers
   logic               s1_idle;
   logic [32:0]        s1_zin;
   logic               s1_zero;
   logic signed [9:0]  s1_exp;
   logic [23:0]        s1_mant;
   logic               s1_g, s1_r, s1_s;
   logic               s1_uf;
   logic [7:0]         s1_tag;
   logic               s1_sv;
   logic [31:0]        s1_z;

   // stage 1 next-state values
   logic signed [9:0]  n_exp;
   logic signed [9:0]  shift_k;
   logic [25:0]        grs;
   logic [25:0]        lost;
   logic               n_s;
   logic               n_uf;

   // stage 2 results
   logic               rnd_up;
   logic [24:0]        sum;
   logic signed [9:0]  r_exp;
   logic [23:0]        r_mant;
   logic [7:0]         r_ef;
   logic               r_ov;
   logic               r_uf;
   logic [32:0]        r_z;

   // Normalise the product so the hidden bit lands in m[23], then shift denormals right.
   always_comb begin
      n_exp   = {{2{zout_Multiply[31]}}, zout_Multiply[31:24]};
      shift_k = '0;
      lost    = '0;
      n_uf    = 1'b0;
      if (productout_Multiply[49]) begin
         grs = productout_Multiply[49:24];
         n_s = |productout_Multiply[23:0];
      end else begin
         grs   = productout_Multiply[48:23];
         n_s   = |productout_Multiply[22:0];
         n_exp = n_exp - 10'sd1;
      end
      if (n_exp < -10'sd126) begin
         n_uf = 1'b1;
         if (DENORM_EN) begin
            shift_k = -10'sd126 - n_exp;
            if (shift_k >= 10'sd26) begin
               n_s = n_s | (|grs);
               grs = '0;
            end else begin
               lost = grs & ~(26'h3FFFFFF << shift_k);
               grs  = grs >> shift_k;
               n_s  = n_s | (|lost);
            end
         end else begin
            // flushed results must not round back up, so guard/round/sticky go too
            grs = '0;
            n_s = 1'b0;
         end
         n_exp = -10'sd126;
      end
   end

   // Capture stage 1 results and sidebands.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_idle <= 1'b0;
         s1_zin  <= '0;
         s1_zero <= 1'b0;
         s1_exp  <= '0;
         s1_mant <= '0;
         s1_g    <= 1'b0;
         s1_r    <= 1'b0;
         s1_s    <= 1'b0;
         s1_uf   <= 1'b0;
         s1_tag  <= '0;
         s1_sv   <= 1'b0;
         s1_z    <= '0;
      end else begin
         s1_idle <= idle_Multiply;
         s1_zin  <= zout_Multiply;
         s1_zero <= (productout_Multiply == 50'd0);
         s1_exp  <= n_exp;
         s1_mant <= grs[25:2];
         s1_g    <= grs[1];
         s1_r    <= grs[0];
         s1_s    <= n_s;
         s1_uf   <= n_uf;
         s1_tag  <= InsTagMultiply;
         s1_sv   <= ScaleValidMultiply;
         s1_z    <= z_Multiply;
      end
   end

   // Round to nearest even, fix up exponent on carry-out, detect overflow, select bypass/zero.
   always_comb begin
      rnd_up = ROUND_EN && s1_g && (s1_r || s1_s || s1_mant[0]);
      sum    = {1'b0, s1_mant} + {24'd0, rnd_up};
      r_exp  = s1_exp;
      r_mant = sum[23:0];
      r_uf   = s1_uf;
      r_ov   = 1'b0;
      if (sum[24]) begin
         r_mant = 24'h800000;
         r_exp  = s1_exp + 10'sd1;
      end
      // a denormal that rounded up into the hidden bit is the smallest normal
      if (r_uf && r_mant[23]) begin
         r_uf = 1'b0;
      end
      if (r_exp > 10'sd127) begin
         r_ov   = 1'b1;
         r_ef   = 8'h80;
         r_mant = '0;
      end else begin
         r_ef = r_exp[7:0];
      end
      r_z = {s1_zin[32], r_ef, r_mant};
      if (s1_zero) begin
         r_z  = {s1_zin[32], 8'h81, 24'h0};
         r_ov = 1'b0;
         r_uf = 1'b0;
      end
      if (s1_idle) begin
         r_z  = s1_zin;
         r_ov = 1'b0;
         r_uf = 1'b0;
      end
   end

   // Register stage 2 outputs; idle resets high so the pack stage sees nothing to do.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idle_NormaliseProd      <= 1'b1;
         zout_NormaliseProd      <= '0;
         InsTagNormaliseProd     <= '0;
         ScaleValidNormaliseProd <= 1'b0;
         z_NormaliseProd         <= '0;
         overflow_NormaliseProd  <= 1'b0;
         underflow_NormaliseProd <= 1'b0;
      end else begin
         idle_NormaliseProd      <= s1_idle;
         zout_NormaliseProd      <= r_z;
         InsTagNormaliseProd     <= s1_tag;
         ScaleValidNormaliseProd <= s1_sv;
         z_NormaliseProd         <= s1_z;
         overflow_NormaliseProd  <= r_ov;
         underflow_NormaliseProd <= r_uf;
      end
   end

endmodule

// File: tb/tb_normalise_prod_mult_descale.sv
// Bench for normalise_prod_mult_descale: directed cases plus random products vs arithmetic model.
// Two instances share inputs: default (round + denormal) and truncate + flush.
// Expected results are queued at drive time and compared two clocks later.
module tb_normalise_prod_mult_descale;

   logic        clock = 1'b0;
   logic        reset;
   logic        idle_m;
   logic [32:0] zin;
   logic [49:0] prod;
   logic [7:0]  tag_in;
   logic        sv_in;
   logic [31:0] z_in;

   logic        idle_a, sv_a, ov_a, uf_a;
   logic [32:0] zout_a;
   logic [7:0]  tag_a;
   logic [31:0] z_a;
   logic        idle_b, sv_b, ov_b, uf_b;
   logic [32:0] zout_b;
   logic [7:0]  tag_b;
   logic [31:0] z_b;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic        idle;
      logic [32:0] za;
      logic        ova, ufa;
      logic [32:0] zb;
      logic        ovb, ufb;
      logic [7:0]  tag;
      logic        sv;
      logic [31:0] z;
   } exp_t;

   exp_t q[$];

   always #5 clock = ~clock;

   normalise_prod_mult_descale dut_a (
      .clock(clock), .reset(reset), .idle_Multiply(idle_m), .zout_Multiply(zin),
      .productout_Multiply(prod), .InsTagMultiply(tag_in), .ScaleValidMultiply(sv_in),
      .z_Multiply(z_in), .idle_NormaliseProd(idle_a), .zout_NormaliseProd(zout_a),
      .InsTagNormaliseProd(tag_a), .ScaleValidNormaliseProd(sv_a), .z_NormaliseProd(z_a),
      .overflow_NormaliseProd(ov_a), .underflow_NormaliseProd(uf_a));

   normalise_prod_mult_descale #(.ROUND_EN(1'b0), .DENORM_EN(1'b0)) dut_b (
      .clock(clock), .reset(reset), .idle_Multiply(idle_m), .zout_Multiply(zin),
      .productout_Multiply(prod), .InsTagMultiply(tag_in), .ScaleValidMultiply(sv_in),
      .z_Multiply(z_in), .idle_NormaliseProd(idle_b), .zout_NormaliseProd(zout_b),
      .InsTagNormaliseProd(tag_b), .ScaleValidNormaliseProd(sv_b), .z_NormaliseProd(z_b),
      .overflow_NormaliseProd(ov_b), .underflow_NormaliseProd(uf_b));

   // Value-level reference: exact integer shift with remainder-based nearest-even rounding.
   function automatic void model(input logic idle, input logic [32:0] zi, input logic [49:0] p_in,
                                 input bit rnd_en, input bit den_en,
                                 output logic [32:0] zo, output logic ov, output logic uf);
      longint unsigned p, mant, rem, half, one;
      int e, t;
      logic sg;
      zo = zi; ov = 1'b0; uf = 1'b0;
      if (idle) return;
      sg = zi[32];
      if (p_in == 50'd0) begin
         zo = {sg, 8'h81, 24'h0};
         return;
      end
      one = 64'd1;
      p = 64'(p_in);
      e = int'($signed(zi[31:24]));
      if (p >= (one << 49)) t = 26;
      else begin t = 25; e = e - 1; end
      if (e < -126) begin
         uf = 1'b1;
         if (!den_en) begin
            zo = {sg, 8'h82, 24'h0};
            return;
         end
         t = t + (-126 - e);
         e = -126;
      end
      mant = p >> t;
      rem  = p & ((one << t) - 1);
      half = one << (t - 1);
      if (rnd_en && (rem > half || (rem == half && mant[0]))) mant++;
      if (mant == (one << 24)) begin mant = one << 23; e++; end
      if (uf && mant >= (one << 23)) uf = 1'b0;
      if (e > 127) begin
         ov = 1'b1;
         zo = {sg, 8'h80, 24'h0};
      end else begin
         zo = {sg, 8'(e), 24'(mant)};
      end
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", name, obs, expv);
      end
   endtask

   task automatic check_out();
      exp_t e;
      e = q.pop_front();
      chk("idle_a", 64'(idle_a), 64'(e.idle));
      chk("zout_a", 64'(zout_a), 64'(e.za));
      chk("ovf_a",  64'(ov_a),   64'(e.ova));
      chk("udf_a",  64'(uf_a),   64'(e.ufa));
      chk("tag_a",  64'(tag_a),  64'(e.tag));
      chk("sv_a",   64'(sv_a),   64'(e.sv));
      chk("z_a",    64'(z_a),    64'(e.z));
      chk("idle_b", 64'(idle_b), 64'(e.idle));
      chk("zout_b", 64'(zout_b), 64'(e.zb));
      chk("ovf_b",  64'(ov_b),   64'(e.ovb));
      chk("udf_b",  64'(uf_b),   64'(e.ufb));
      chk("tag_b",  64'(tag_b),  64'(e.tag));
      chk("sv_b",   64'(sv_b),   64'(e.sv));
      chk("z_b",    64'(z_b),    64'(e.z));
   endtask

   // One clock: check the result due now, then drive a new op (use_c forces hand-derived A result).
   task automatic step(input logic idle, input logic [32:0] zi, input logic [49:0] p,
                       input logic [7:0] tg, input logic sv, input logic [31:0] z,
                       input bit use_c, input logic [32:0] cz, input logic cov, input logic cuf);
      exp_t e;
      @(posedge clock); #1;
      if (q.size() >= 2) check_out();
      idle_m = idle; zin = zi; prod = p; tag_in = tg; sv_in = sv; z_in = z;
      e.idle = idle; e.tag = tg; e.sv = sv; e.z = z;
      model(idle, zi, p, 1'b1, 1'b1, e.za, e.ova, e.ufa);
      model(idle, zi, p, 1'b0, 1'b0, e.zb, e.ovb, e.ufb);
      if (use_c) begin
         e.za = cz; e.ova = cov; e.ufa = cuf;
      end
      q.push_back(e);
   endtask

   task automatic rand_step();
      logic [23:0] a, b;
      logic [7:0]  ex;
      logic [49:0] p;
      logic [32:0] zi;
      a = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
      b = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
      p = 50'((longint'(a) * longint'(b)) << 2);
      if ($urandom_range(0, 15) == 0) p = '0;
      case ($urandom_range(0, 9))
         0: ex = 8'h80;
         1: ex = 8'h81;
         2: ex = 8'h82;
         3: ex = 8'h7F;
         default: ex = 8'($urandom);
      endcase
      zi = {1'($urandom), ex, 24'($urandom)};
      step(($urandom_range(0, 3) == 0), zi, p, 8'($urandom), 1'($urandom), $urandom,
           1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic reset_vals(input string tg);
      chk({tg, "_idle"}, 64'(idle_a), 64'd1);
      chk({tg, "_zout"}, 64'(zout_a), 64'd0);
      chk({tg, "_tag"},  64'(tag_a),  64'd0);
      chk({tg, "_sv"},   64'(sv_a),   64'd0);
      chk({tg, "_z"},    64'(z_a),    64'd0);
      chk({tg, "_ovf"},  64'(ov_a),   64'd0);
      chk({tg, "_udf"},  64'(uf_a),   64'd0);
      chk({tg, "_idle_b"}, 64'(idle_b), 64'd1);
   endtask

   initial begin
      reset = 1'b1; idle_m = 1'b0; zin = '0; prod = '0; tag_in = '0; sv_in = 1'b0; z_in = '0;
      #2;
      reset_vals("por");
      #6 reset = 1'b0;

      // 1.0*1.0, 1.5*1.5
      step(1'b0, {1'b0, 8'h01, 24'h0}, 50'h1_0000_0000_0000, 8'h11, 1'b1, 32'h1111_0001,
           1'b1, {1'b0, 8'h00, 24'h800000}, 1'b0, 1'b0);
      step(1'b0, {1'b0, 8'h01, 24'h0}, 50'h2_4000_0000_0000, 8'h12, 1'b0, 32'h1111_0002,
           1'b1, {1'b0, 8'h01, 24'h900000}, 1'b0, 1'b0);
      // rounding: round up, tie to even, carry-out
      step(1'b0, {1'b0, 8'h01, 24'h0}, {24'h800001, 1'b1, 25'd0}, 8'h13, 1'b1, 32'h1111_0003,
           1'b1, {1'b0, 8'h01, 24'h800002}, 1'b0, 1'b0);
      step(1'b0, {1'b0, 8'h01, 24'h0}, {24'h800000, 1'b1, 25'd0}, 8'h14, 1'b0, 32'h1111_0004,
           1'b1, {1'b0, 8'h01, 24'h800000}, 1'b0, 1'b0);
      step(1'b0, {1'b0, 8'h05, 24'h0}, {24'hFFFFFF, 1'b1, 25'd0}, 8'h15, 1'b1, 32'h1111_0005,
           1'b1, {1'b0, 8'h06, 24'h800000}, 1'b0, 1'b0);
      // denormal k=2, overflow, denormal rounding into normal, zero product
      step(1'b0, {1'b1, 8'h81, 24'h0}, 50'h1_0000_0000_0000, 8'h16, 1'b0, 32'h1111_0006,
           1'b1, {1'b1, 8'h82, 24'h200000}, 1'b0, 1'b1);
      step(1'b0, {1'b0, 8'h7F, 24'h0}, {24'hFFFFFF, 1'b1, 25'd0}, 8'h17, 1'b1, 32'h1111_0007,
           1'b1, {1'b0, 8'h80, 24'h000000}, 1'b1, 1'b0);
      step(1'b0, {1'b0, 8'h81, 24'h0}, 50'h3_FFFF_FFFF_FFFF, 8'h18, 1'b0, 32'h1111_0008,
           1'b1, {1'b0, 8'h82, 24'h800000}, 1'b0, 1'b0);
      step(1'b0, {1'b1, 8'h33, 24'h0}, 50'd0, 8'h19, 1'b1, 32'h1111_0009,
           1'b1, {1'b1, 8'h81, 24'h000000}, 1'b0, 1'b0);
      // idle bypass then non-idle back-to-back
      step(1'b1, 33'h1_2345_6789, 50'h2_4000_0000_0000, 8'hA5, 1'b1, 32'hDEAD_BEEF,
           1'b1, 33'h1_2345_6789, 1'b0, 1'b0);
      step(1'b0, {1'b0, 8'h01, 24'h0}, 50'h2_4000_0000_0000, 8'h5A, 1'b0, 32'hCAFE_F00D,
           1'b1, {1'b0, 8'h01, 24'h900000}, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++) rand_step();

      // reset with two operations in flight
      step(1'b0, {1'b0, 8'h01, 24'h0}, 50'h2_4000_0000_0000, 8'hC3, 1'b1, 32'h5555_AAAA,
           1'b0, '0, 1'b0, 1'b0);
      step(1'b0, {1'b0, 8'h05, 24'h0}, 50'h1_0000_0000_0000, 8'h3C, 1'b1, 32'hAAAA_5555,
           1'b0, '0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      idle_m = 1'b0; zin = '0; prod = '0; tag_in = '0; sv_in = 1'b0; z_in = '0;
      #1;
      reset_vals("rst_async");
      q.delete();
      @(posedge clock); #1;
      reset_vals("rst_held");
      #1 reset = 1'b0;
      @(posedge clock); #1;
      chk("rst_flush_tag", 64'(tag_a), 64'd0);
      chk("rst_flush_z",   64'(z_a),   64'd0);
      chk("rst_flush_sv",  64'(sv_a),  64'd0);

      for (int i = 0; i < 60; i++) rand_step();
      @(posedge clock); #1; check_out();
      @(posedge clock); #1; check_out();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
